// File: rtl/ce_gen_multi_if.sv
// Control/status bundle for ce_gen_multi: increment writes, ch0 speed/pause/step
// controls, and the per-channel clock-enable outputs.
interface ce_gen_multi_if #(
  parameter int NUM_CH = 4,
  parameter int ACC_W  = 24,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [ACC_W-1:0]  wr_inc;
  logic [1:0]        speed_sel;
  logic              pause;
  logic              step;
  logic              acc_clr;
  logic [NUM_CH-1:0] ce;
  logic [1:0]        speed_act;

  // Controller side: drives controls, observes enables.
  modport master (
    output wr_en, wr_ch, wr_inc, speed_sel, pause, step, acc_clr,
    input  ce, speed_act
  );

  // Generator side: consumes controls, produces enables.
  modport slave (
    input  wr_en, wr_ch, wr_inc, speed_sel, pause, step, acc_clr,
    output ce, speed_act
  );
endinterface

// File: rtl/ce_gen_multi.sv
// Multi-channel clock-enable generator. Each channel is a fractional phase
// accumulator; its carry out becomes a registered 1-cycle ce pulse.
// Channel 0 has a 1x/2x/4x/8x speed multiplier that only switches on a pulse
// boundary, plus pause/single-step control. Single clock domain, no gating.
module ce_gen_multi #(
  parameter int                      NUM_CH     = 4,
  parameter int                      ACC_W      = 24,
  parameter logic [NUM_CH*ACC_W-1:0] DEF_INC    = ((NUM_CH*ACC_W)'(17) << ACC_W)
                                                | (NUM_CH*ACC_W)'(1398),
  parameter logic [NUM_CH-1:0]       PAUSE_MASK = NUM_CH'(4'b0011)
) (
  input  logic           clk,
  input  logic           reset,
  ce_gen_multi_if.slave  bus
);

  // Three spare bits hold the worst-case 8x shift before saturation.
  localparam int SHL_W = ACC_W + 3;

  logic [ACC_W-1:0]  r_acc [NUM_CH];
  logic [ACC_W-1:0]  r_inc [NUM_CH];
  logic [NUM_CH-1:0] r_ce;
  logic [1:0]        r_speed_act;
  logic              r_step_q;

  logic [SHL_W-1:0]  w_inc0_shl;
  logic [ACC_W-1:0]  w_eff_inc [NUM_CH];
  logic [ACC_W:0]    w_sum     [NUM_CH];
  logic [NUM_CH-1:0] w_run;
  logic              w_step_pulse;
  logic              w_ch0_carry;
  logic              w_speed_upd;
  logic              w_wr_ok;

  // Effective increments, accumulator sums and per-channel run enables.
  always_comb begin
    w_inc0_shl = {3'b000, r_inc[0]} << r_speed_act;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_eff_inc[i] = r_inc[i];
      w_run[i]     = ~(bus.pause & PAUSE_MASK[i]);
    end
    // ch0 saturates instead of wrapping when the multiplied increment overflows.
    w_eff_inc[0] = (|w_inc0_shl[SHL_W-1:ACC_W]) ? '1 : w_inc0_shl[ACC_W-1:0];
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_sum[i] = {1'b0, r_acc[i]} + {1'b0, w_eff_inc[i]};
    end
  end

  // Step edge, ch0 boundary detection and write qualification.
  always_comb begin
    w_step_pulse = bus.step & ~r_step_q & bus.pause;
    w_ch0_carry  = w_sum[0][ACC_W] & w_run[0] & ~bus.acc_clr;
    // A stopped or frozen ch0 has no boundary to wait for, so switch at once.
    w_speed_upd  = w_ch0_carry | (r_inc[0] == '0) | ~w_run[0];
    w_wr_ok      = bus.wr_en & (32'(bus.wr_ch) < 32'(NUM_CH));
  end

  // Accumulators, registered enables, increments, speed and step history.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_acc[i] <= '0;
        r_inc[i] <= DEF_INC[i*ACC_W +: ACC_W];
      end
      r_ce        <= '0;
      r_speed_act <= '0;
      r_step_q    <= 1'b0;
    end else begin
      r_step_q <= bus.step;
      if (w_speed_upd) begin
        r_speed_act <= bus.speed_sel;
      end
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (bus.acc_clr) begin
          r_acc[i] <= '0;
          r_ce[i]  <= 1'b0;
        end else if (w_run[i]) begin
          r_acc[i] <= w_sum[i][ACC_W-1:0];
          r_ce[i]  <= w_sum[i][ACC_W];
        end else begin
          r_ce[i]  <= 1'b0;
        end
      end
      // A step edge still fires through acc_clr; acc[0] is left alone.
      if (w_step_pulse) begin
        r_ce[0] <= 1'b1;
      end
      // The old increment has already been used for this cycle's add.
      if (w_wr_ok) begin
        r_inc[bus.wr_ch] <= bus.wr_inc;
      end
    end
  end

  assign bus.ce        = r_ce;
  assign bus.speed_act = r_speed_act;

endmodule

// File: tb/tb_ce_gen_multi.sv
// Bench for ce_gen_multi (NUM_CH=2, ACC_W=8, ch0 inc 64, ch1 inc 0, ch0 pausable).
// Stimulus pushes hand-computed pulse cycles and speed changes into queues;
// a negedge monitor pops and compares whenever a ce pulse or speed change shows.
module tb_ce_gen_multi;
  localparam int NCH = 2;
  localparam int AW  = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ce_gen_multi_if #(.NUM_CH(NCH), .ACC_W(AW)) bus ();

  ce_gen_multi #(
    .NUM_CH    (NCH),
    .ACC_W     (AW),
    .DEF_INC   ({8'd0, 8'd64}),
    .PAUSE_MASK(2'b01)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;
  logic [1:0] prev_spd;
  int   q0[$];
  int   q1[$];
  int   qs_cyc[$];
  int   qs_val[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every ce pulse and every speed_act change must match the queues.
  always @(negedge clk) begin
    prev_spd <= bus.speed_act;
    if (mon_en) begin
      if (bus.ce[0] !== 1'b0) begin
        if (q0.size() == 0) begin
          total++; bad++;
          $display("FAIL ce0_extra: pulse at cycle %0d, expected none", cyc);
        end else chk("ce0_cycle", cyc, q0.pop_front());
      end
      if (bus.ce[1] !== 1'b0) begin
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL ce1_extra: pulse at cycle %0d, expected none", cyc);
        end else chk("ce1_cycle", cyc, q1.pop_front());
      end
      if (bus.speed_act !== prev_spd) begin
        if (qs_cyc.size() == 0) begin
          total++; bad++;
          $display("FAIL speed_extra: speed_act=%0d at cycle %0d, expected no change",
                   bus.speed_act, cyc);
        end else begin
          chk("speed_cycle", cyc, qs_cyc.pop_front());
          chk("speed_val", int'(bus.speed_act), qs_val.pop_front());
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic drain(input string tag);
    chk({tag, "_ce0_missing"}, q0.size(), 0);
    chk({tag, "_ce1_missing"}, q1.size(), 0);
    chk({tag, "_speed_missing"}, qs_cyc.size(), 0);
  endtask

  task automatic wr(input logic ch, input logic [AW-1:0] v);
    bus.wr_en  = 1'b1;
    bus.wr_ch  = ch;
    bus.wr_inc = v;
    tick(1);
    bus.wr_en  = 1'b0;
  endtask

  task automatic push_spd(input int c, input int v);
    qs_cyc.push_back(c);
    qs_val.push_back(v);
  endtask

  int t;

  initial begin
    reset         = 1'b1;
    bus.wr_en     = 1'b0;
    bus.wr_ch     = 1'b0;
    bus.wr_inc    = '0;
    bus.speed_sel = 2'd0;
    bus.pause     = 1'b0;
    bus.step      = 1'b0;
    bus.acc_clr   = 1'b0;
    tick(2);
    reset  = 1'b0;
    mon_en = 1'b1;
    chk("reset_ce", int'(bus.ce), 0);
    chk("reset_speed", int'(bus.speed_act), 0);

    // 1: inc 64 -> pulse every 4th cycle, first one 4 edges after release.
    t = cyc;
    for (int k = 1; k <= 16; k++) q0.push_back(t + 4 * k);
    tick(64);
    drain("p1");

    // 2: 2x requested mid-period; takes effect on the next carry.
    t = cyc;
    tick(2);
    bus.speed_sel = 2'd1;
    push_spd(t + 4, 1);
    q0.push_back(t + 4);
    for (int k = 1; k <= 6; k++) q0.push_back(t + 4 + 2 * k);
    tick(14);
    drain("p2");

    // 3: ch1 inc=3 -> three ch1 pulses over the next 256 cycles.
    t = cyc;
    for (int k = 1; k <= 129; k++) q0.push_back(t + 2 * k);
    q1.push_back(t + 87);
    q1.push_back(t + 172);
    q1.push_back(t + 257);
    wr(1'b1, 8'd3);
    tick(257);
    drain("p3");

    // 4: pause freezes ch0 at acc=128; three step edges; release resumes from 128.
    t = cyc;
    tick(1);
    bus.pause     = 1'b1;
    bus.speed_sel = 2'd0;
    push_spd(t + 2, 0);
    q1.push_back(t + 85);
    q0.push_back(t + 3);
    q0.push_back(t + 13);
    q0.push_back(t + 23);
    q0.push_back(t + 92);
    q0.push_back(t + 96);
    q0.push_back(t + 100);
    tick(1);
    for (int e = 0; e < 3; e++) begin
      bus.step = 1'b1;
      tick(5);
      bus.step = 1'b0;
      tick(5);
    end
    tick(58);
    bus.pause = 1'b0;
    tick(10);
    drain("p4");

    // 4b: step edge without pause is ignored.
    t = cyc;
    q0.push_back(t + 4);
    bus.step = 1'b1;
    tick(2);
    bus.step = 1'b0;
    tick(2);
    drain("p4b");

    // 5: inc 200 at 8x saturates to 255 -> 255 pulses in 256 cycles.
    t = cyc;
    bus.speed_sel = 2'd3;
    push_spd(t + 2, 3);
    for (int k = 2; k <= 10; k++) q0.push_back(t + k);
    for (int k = 12; k <= 266; k++) q0.push_back(t + k);
    q1.push_back(t + 66);
    q1.push_back(t + 151);
    q1.push_back(t + 237);
    wr(1'b0, 8'd200);
    tick(265);
    drain("p5");

    // 5b: inc 0 stops ch0; speed then switches without waiting for a carry.
    t = cyc;
    push_spd(t + 2, 2);
    q1.push_back(t + 56);
    q1.push_back(t + 141);
    q1.push_back(t + 227);
    wr(1'b0, 8'd0);
    bus.speed_sel = 2'd2;
    tick(299);
    drain("p5b");

    // 6: acc_clr mid-period restarts phase from 0 (ch1's carry at +12 also vanishes).
    t = cyc;
    bus.speed_sel = 2'd0;
    push_spd(t + 1, 0);
    q0.push_back(t + 2);
    q0.push_back(t + 8);
    q0.push_back(t + 12);
    q0.push_back(t + 16);
    wr(1'b0, 8'd64);
    tick(2);
    bus.acc_clr = 1'b1;
    tick(1);
    bus.acc_clr = 1'b0;
    tick(12);
    drain("p6");

    // 6b: reset mid-period restores default increments and speed 1x.
    t = cyc;
    bus.speed_sel = 2'd1;
    push_spd(t + 7, 1);
    push_spd(t + 10, 0);
    q0.push_back(t + 7);
    for (int k = 1; k <= 8; k++) q0.push_back(t + 10 + 4 * k);
    wr(1'b0, 8'd32);
    tick(8);
    reset         = 1'b1;
    bus.speed_sel = 2'd0;
    tick(1);
    reset = 1'b0;
    tick(32);
    drain("p6b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
